// File: rtl/hdr_ram_ctrl.sv
// Frame-oriented circular-buffer controller for a dual-port header RAM.
// Optional statistics outputs are enabled by defining HDR_RAM_CTRL_STATS_EN.
module hdr_ram_ctrl #(
  parameter int DATA_WIDTH = 17,
  parameter int RAM_ADRB   = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  ram_wea,
  output logic [RAM_ADRB-1:0]   ram_adra,
  output logic [DATA_WIDTH:0]   ram_dataa,
  output logic                  ram_enb,
  output logic [RAM_ADRB-1:0]   ram_adrb,
  input  logic [DATA_WIDTH:0]   ram_datab,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [RAM_ADRB-1:0]   frame_cnt,
  output logic [RAM_ADRB-1:0]   words_used,
  output logic                  wr_drop,
`ifdef HDR_RAM_CTRL_STATS_EN
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_drops,
  output logic [RAM_ADRB-1:0]   stat_peak,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {W_IDLE, W_OPEN, W_DROP} wstate_t;

  localparam logic [RAM_ADRB-1:0] ONE = RAM_ADRB'(1);

  wstate_t             state_q, state_d;
  logic [RAM_ADRB-1:0] wadr_q, wadr_d;
  logic [RAM_ADRB-1:0] wcommit_q, wcommit_d;
  logic [RAM_ADRB-1:0] radr_q, radr_d;
  logic [RAM_ADRB-1:0] frame_cnt_q, frame_cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_drop_q, wr_drop_d;

  logic [RAM_ADRB-1:0] radr_base;
  logic                full, wr_go, wr_acc, commit;
  logic                avail, enb, rd_acc, last_acc;

  // The word presented on rd_data is still owned by the buffer until accepted.
  assign radr_base = radr_q - (rd_valid_q ? ONE : '0);
  assign full      = (wadr_q + ONE) == radr_base;
  assign wr_go     = wr_en & ~reset;

  always_comb begin
    state_d   = state_q;
    wadr_d    = wadr_q;
    wcommit_d = wcommit_q;
    wr_drop_d = 1'b0;
    wr_acc    = 1'b0;
    commit    = 1'b0;
    if (wr_go) begin
      case (state_q)
        W_IDLE, W_OPEN: begin
          if (!full) begin
            wr_acc = 1'b1;
            wadr_d = wadr_q + ONE;
            if (wr_last) begin
              commit    = 1'b1;
              wcommit_d = wadr_q + ONE;
              state_d   = W_IDLE;
            end else begin
              state_d = W_OPEN;
            end
          end else begin
            // Overflow: rewind to the last commit and swallow the rest of the frame.
            wadr_d    = wcommit_q;
            wr_drop_d = 1'b1;
            state_d   = wr_last ? W_IDLE : W_DROP;
          end
        end
        W_DROP: begin
          if (wr_last) state_d = W_IDLE;
        end
        default: state_d = W_IDLE;
      endcase
    end
  end

  assign avail    = radr_q != wcommit_q;
  assign rd_acc   = rd_valid_q & rd_ready;
  assign enb      = ~reset & avail & (~rd_valid_q | rd_ready);
  assign last_acc = rd_acc & ram_datab[DATA_WIDTH];

  always_comb begin
    radr_d      = enb ? radr_q + ONE : radr_q;
    rd_valid_d  = enb ? 1'b1 : (rd_acc ? 1'b0 : rd_valid_q);
    frame_cnt_d = frame_cnt_q + (commit ? ONE : '0) - (last_acc ? ONE : '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= W_IDLE;
      wadr_q      <= '0;
      wcommit_q   <= '0;
      radr_q      <= '0;
      frame_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wadr_q      <= wadr_d;
      wcommit_q   <= wcommit_d;
      radr_q      <= radr_d;
      frame_cnt_q <= frame_cnt_d;
      rd_valid_q  <= rd_valid_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  assign ram_wea    = wr_acc;
  assign ram_adra   = wadr_q;
  assign ram_dataa  = {wr_last, wr_data};
  assign ram_enb    = enb;
  assign ram_adrb   = radr_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = ram_datab[DATA_WIDTH-1:0];
  assign rd_last    = ram_datab[DATA_WIDTH];
  assign frame_cnt  = frame_cnt_q;
  assign words_used = wadr_q - radr_base;
  assign wr_drop    = wr_drop_q;
  assign busy       = (state_q != W_IDLE) | rd_valid_q;

`ifdef HDR_RAM_CTRL_STATS_EN
  logic [15:0]         stat_frames_q, stat_frames_d;
  logic [15:0]         stat_drops_q, stat_drops_d;
  logic [RAM_ADRB-1:0] stat_peak_q, stat_peak_d;

  always_comb begin
    stat_frames_d = stat_frames_q;
    stat_drops_d  = stat_drops_q;
    stat_peak_d   = stat_peak_q;
    if (commit && stat_frames_q != 16'hFFFF) stat_frames_d = stat_frames_q + 16'd1;
    if (wr_drop_d && stat_drops_q != 16'hFFFF) stat_drops_d = stat_drops_q + 16'd1;
    if (words_used > stat_peak_q) stat_peak_d = words_used;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_frames_q <= '0;
      stat_drops_q  <= '0;
      stat_peak_q   <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_drops_q  <= stat_drops_d;
      stat_peak_q   <= stat_peak_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_drops  = stat_drops_q;
  assign stat_peak   = stat_peak_q;
`endif

endmodule

// File: tb/tb_hdr_ram_ctrl.sv
// Scoreboard bench for hdr_ram_ctrl with a behavioural 16x18 RAM model.
module tb_hdr_ram_ctrl;
  localparam int DW = 17;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          ram_wea;
  logic [AW-1:0] ram_adra;
  logic [DW:0]   ram_dataa;
  logic          ram_enb;
  logic [AW-1:0] ram_adrb;
  logic [DW:0]   ram_datab = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [AW-1:0] frame_cnt;
  logic [AW-1:0] words_used;
  logic          wr_drop;
  logic          busy;
`ifdef HDR_RAM_CTRL_STATS_EN
  logic [15:0]   stat_frames;
  logic [15:0]   stat_drops;
  logic [AW-1:0] stat_peak;
`endif

  hdr_ram_ctrl #(.DATA_WIDTH(DW), .RAM_ADRB(AW)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .ram_wea(ram_wea), .ram_adra(ram_adra), .ram_dataa(ram_dataa),
    .ram_enb(ram_enb), .ram_adrb(ram_adrb), .ram_datab(ram_datab),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .frame_cnt(frame_cnt), .words_used(words_used), .wr_drop(wr_drop),
`ifdef HDR_RAM_CTRL_STATS_EN
    .stat_frames(stat_frames), .stat_drops(stat_drops), .stat_peak(stat_peak),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  logic [DW:0] mem [16];
  always @(posedge clock) begin
    if (ram_wea) mem[ram_adra] <= ram_dataa;
    if (ram_enb) ram_datab <= mem[ram_adrb];
  end

  int n_cmp = 0;
  int n_mis = 0;
  int drop_cnt = 0;
  logic [DW:0] sbq [$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare every word the consumer takes against the oldest expected word.
  always @(negedge clock) begin
    if (!reset && rd_valid && rd_ready) begin
      if (sbq.size() == 0) chk_val("sb_unexpected_word", {rd_last, rd_data}, 32'hDEAD);
      else chk_val("sb_word", {rd_last, rd_data}, sbq.pop_front());
    end
    if (wr_drop) drop_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input logic l, input bit keep);
    wr_en = 1'b1;
    wr_data = d;
    wr_last = l;
    if (keep) sbq.push_back({l, d});
    step();
    wr_en = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0 && !rd_valid) break;
      step();
    end
    chk_val("drain_done", {31'd0, (sbq.size() == 0 && !rd_valid)}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk_val("rst_rd_valid", rd_valid, 0);
    chk_val("rst_frame_cnt", frame_cnt, 0);
    chk_val("rst_words_used", words_used, 0);
    chk_val("rst_wr_drop", wr_drop, 0);
    chk_val("rst_ram_enb", ram_enb, 0);
    chk_val("rst_ram_wea", ram_wea, 0);
    chk_val("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // 3-word frame with consumer always ready
    rd_ready = 1'b1;
    wr_word(17'h1A, 1'b0, 1'b1);
    wr_word(17'h1B, 1'b0, 1'b1);
    wr_word(17'h1C, 1'b1, 1'b1);
    chk_val("t1_frame_cnt_commit", frame_cnt, 1);
    chk_val("t1_valid_latency", rd_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_val("t1_valid", rd_valid, 1);
      chk_val("t1_data", rd_data, 32'h1A + i);
      chk_val("t1_last", rd_last, (i == 2) ? 1 : 0);
    end
    step();
    chk_val("t1_valid_end", rd_valid, 0);
    chk_val("t1_frame_cnt_end", frame_cnt, 0);
    chk_val("t1_words_used_end", words_used, 0);

    // Stalled consumer, one accept at a time
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr_word(17'h20 + i, (i == 4), 1'b1);
    step();
    step();
    chk_val("t2_valid_stall", rd_valid, 1);
    chk_val("t2_data_hold0", rd_data, 32'h20);
    chk_val("t2_words_used", words_used, 5);
    for (int i = 0; i < 2; i++) begin
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk_val("t2_data_adv", rd_data, 32'h21 + i);
      step();
      step();
      chk_val("t2_data_stable", rd_data, 32'h21 + i);
      chk_val("t2_valid_stable", rd_valid, 1);
    end
    drain();
    chk_val("t2_frame_cnt_end", frame_cnt, 0);

    // Overflow: 14-word frame A fits, frame B overflows on its second word
    rd_ready = 1'b0;
    drop_cnt = 0;
    for (int i = 0; i < 14; i++) wr_word(17'h100 + i, (i == 13), 1'b1);
    for (int i = 0; i < 3; i++) wr_word(17'h200 + i, (i == 2), 1'b0);
    step();
    step();
    chk_val("t3_drop_pulses", drop_cnt, 1);
    chk_val("t3_words_used", words_used, 14);
    chk_val("t3_frame_cnt", frame_cnt, 1);
`ifdef HDR_RAM_CTRL_STATS_EN
    chk_val("t3_stat_drops", stat_drops, 1);
`endif
    drain();
    chk_val("t3_frame_cnt_end", frame_cnt, 0);

    // Wrap-around: 10 words then 12 words through the ring
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) wr_word(17'h300 + i, (i == 9), 1'b1);
    drain();
    for (int i = 0; i < 12; i++) wr_word(17'h400 + i, (i == 11), 1'b1);
    drain();
    chk_val("t4_words_used", words_used, 0);

    // Commit coinciding with last-word accept of previous frame
    rd_ready = 1'b0;
    wr_word(17'h50, 1'b0, 1'b1);
    wr_word(17'h51, 1'b1, 1'b1);
    step();
    step();
    chk_val("t5_valid", rd_valid, 1);
    chk_val("t5_frame_cnt_pre", frame_cnt, 1);
    rd_ready = 1'b1;
    wr_word(17'h60, 1'b0, 1'b1);
    chk_val("t5_frame_cnt_mid", frame_cnt, 1);
    wr_word(17'h61, 1'b1, 1'b1);
    rd_ready = 1'b0;
    chk_val("t5_frame_cnt_same", frame_cnt, 1);
    drain();
    chk_val("t5_frame_cnt_end", frame_cnt, 0);

    // Reset mid-frame while a committed frame is presented
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr_word(17'h70 + i, (i == 2), 1'b0);
    step();
    step();
    chk_val("t6_valid_pre", rd_valid, 1);
    wr_word(17'h80, 1'b0, 1'b0);
    wr_word(17'h81, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_val("t6_rst_valid", rd_valid, 0);
    chk_val("t6_rst_frame_cnt", frame_cnt, 0);
    chk_val("t6_rst_words_used", words_used, 0);
    chk_val("t6_rst_busy", busy, 0);
    chk_val("t6_rst_adra", ram_adra, 0);
    chk_val("t6_rst_adrb", ram_adrb, 0);
    chk_val("t6_rst_enb", ram_enb, 0);
    reset = 1'b0;
    rd_ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 17'h3A;
    wr_last = 1'b0;
    sbq.push_back({1'b0, 17'h3A});
    #1;
    chk_val("t6_wea", ram_wea, 1);
    chk_val("t6_adra0", ram_adra, 0);
    step();
    wr_en = 1'b0;
    wr_word(17'h3B, 1'b1, 1'b1);
    drain();
    chk_val("t6_frame_cnt_end", frame_cnt, 0);
`ifdef HDR_RAM_CTRL_STATS_EN
    chk_val("t6_stat_frames", stat_frames, 1);
    chk_val("t6_stat_drops", stat_drops, 0);
    chk_val("t6_stat_peak", stat_peak, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
